dff_pipeline: RTL and testbench

//  Parametrised chain of D flip-flop stages carrying WIDTH-bit data with valid/ready flow control.

---
 rtl/dff_pkg.sv | 13 +
 rtl/dff_pipe_if.sv | 43 ++++
 rtl/dff_pipe_stage.sv | 53 +++++
 rtl/dff_pipeline.sv | 94 +++++++++
 tb/tb_dff_pipeline.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dff_pkg.sv
// Shared definitions for the dff_pipeline slice: default geometry and the
// occupancy-counter width helper.
package dff_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DEPTH = 4;

  // Bits needed to count 0..depth inclusive.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dff_pipe_if.sv
// Producer/consumer bundle for dff_pipeline: input handshake, output
// handshake, synchronous flush and the occupancy report.
interface dff_pipe_if
  import dff_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input logic clk
);

  logic                      clr;
  logic                      in_valid;
  logic                      in_ready;
  logic [WIDTH-1:0]          in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [WIDTH-1:0]          out_data;
  logic [cnt_w(DEPTH)-1:0]   occupancy;

  // Pipeline side.
  modport slave (
    input  clr, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );

  // Producer/consumer side.
  modport master (
    input  clk, in_ready, out_valid, out_data, occupancy,
    output clr, in_valid, in_data, out_ready
  );

  modport DRIVER (
    input  clk, in_ready, out_valid, out_data, occupancy,
    output clr, in_valid, in_data, out_ready
  );

  modport MONITOR (
    input clk, clr, in_valid, in_ready, in_data,
          out_valid, out_ready, out_data, occupancy
  );

endinterface

// File: rtl/dff_pipe_stage.sv
// One pipeline stage: a valid bit plus a data register. The stage accepts
// from upstream whenever it is empty or its downstream neighbour is ready.
module dff_pipe_stage
  import dff_pkg::*;
#(
  parameter int unsigned      WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] data;
  } stage_t;

  stage_t stage_q, stage_d;

  assign ready_o = !stage_q.valid || ready_i;
  assign valid_o = stage_q.valid;
  assign data_o  = stage_q.data;

  // Next state: flush drops the valid only; data moves only with a valid beat.
  always_comb begin
    stage_d = stage_q;
    if (clr_i) begin
      stage_d.valid = 1'b0;
    end else if (ready_o) begin
      stage_d.valid = valid_i;
      if (valid_i) begin
        stage_d.data = data_i;
      end
    end
  end

  // Stage register with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '{valid: 1'b0, data: RESET_VAL};
    end else begin
      stage_q <= stage_d;
    end
  end

endmodule

// File: rtl/dff_pipeline.sv
// Chain of DEPTH handshaked register stages with bubble collapse,
// synchronous flush and a registered occupancy count.
module dff_pipeline
  import dff_pkg::*;
#(
  parameter int unsigned      WIDTH     = DEF_WIDTH,
  parameter int unsigned      DEPTH     = DEF_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic      clk,
  input  logic      rst_n,
  dff_pipe_if.slave bus
);

  localparam int unsigned CW   = cnt_w(DEPTH);
  localparam int          LAST = int'(DEPTH) - 1;

  if (DEPTH < 1) begin : g_bad_depth
    $error("dff_pipeline: DEPTH must be at least 1");
  end

  // Each stage looks up to its predecessor for data and down to its
  // successor for ready; the ends attach to the bus.
  for (genvar i = 0; i < int'(DEPTH); i++) begin : g_st
    logic             up_valid;
    logic [WIDTH-1:0] up_data;
    logic             dn_ready;
    logic             ready;
    logic             valid;
    logic [WIDTH-1:0] data;

    if (i == 0) begin : g_head
      assign up_valid = bus.in_valid;
      assign up_data  = bus.in_data;
    end else begin : g_body
      assign up_valid = g_st[i-1].valid;
      assign up_data  = g_st[i-1].data;
    end

    if (i == LAST) begin : g_tail
      assign dn_ready = bus.out_ready;
    end else begin : g_link
      assign dn_ready = g_st[i+1].ready;
    end

    dff_pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (bus.clr),
      .valid_i (up_valid),
      .data_i  (up_data),
      .ready_i (dn_ready),
      .ready_o (ready),
      .valid_o (valid),
      .data_o  (data)
    );
  end

  assign bus.in_ready  = g_st[0].ready && !bus.clr;
  assign bus.out_valid = g_st[LAST].valid;
  assign bus.out_data  = g_st[LAST].data;

  logic [CW-1:0] occ_q, occ_d;
  logic          in_xfer, out_xfer;

  // Occupancy tracks accepted minus delivered beats; a flush delivers nothing.
  always_comb begin
    in_xfer  = bus.in_valid && bus.in_ready;
    out_xfer = bus.out_valid && bus.out_ready && !bus.clr;
    occ_d    = occ_q;
    if (bus.clr) begin
      occ_d = '0;
    end else if (in_xfer && !out_xfer) begin
      occ_d = occ_q + CW'(1);
    end else if (out_xfer && !in_xfer) begin
      occ_d = occ_q - CW'(1);
    end
  end

  // Occupancy register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign bus.occupancy = occ_q;

endmodule

// File: tb/tb_dff_pipeline.sv
// Scoreboard bench for dff_pipeline: a DEPTH=4 and a DEPTH=1 instance share
// clock and reset; drivers queue each accepted beat and per-instance monitors
// pop and compare on every output transfer.
module tb_dff_pipeline;
  import dff_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dff_pipe_if #(.WIDTH(8), .DEPTH(4)) b4 (.clk(clk));
  dff_pipe_if #(.WIDTH(8), .DEPTH(1)) b1 (.clk(clk));

  dff_pipeline #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'hC3)) u4 (
    .clk(clk), .rst_n(rst_n), .bus(b4));
  dff_pipeline #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h00)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1));

  typedef struct {
    logic [7:0]  d;
    int unsigned c;
  } exp_t;

  exp_t        q4[$];
  exp_t        q1[$];
  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc      = 0;
  int          out4     = 0;
  int          out1     = 0;
  bit          lat4     = 1'b0;
  bit          lat1     = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Monitor for the DEPTH=4 instance.
  always @(negedge b4.clk) begin
    if (rst_n && b4.out_valid && b4.out_ready && !b4.clr) begin
      exp_t e;
      out4++;
      if (q4.size() == 0) begin
        check("u4_unexpected_beat", {24'd0, b4.out_data}, 32'hFFFF_FFFF);
      end else begin
        e = q4.pop_front();
        check("u4_data", {24'd0, b4.out_data}, {24'd0, e.d});
        if (lat4) check("u4_latency", cyc - e.c, 4);
      end
    end
  end

  // Monitor for the DEPTH=1 instance.
  always @(negedge b1.clk) begin
    if (rst_n && b1.out_valid && b1.out_ready && !b1.clr) begin
      exp_t e;
      out1++;
      if (q1.size() == 0) begin
        check("u1_unexpected_beat", {24'd0, b1.out_data}, 32'hFFFF_FFFF);
      end else begin
        e = q1.pop_front();
        check("u1_data", {24'd0, b1.out_data}, {24'd0, e.d});
        if (lat1) check("u1_latency", cyc - e.c, 1);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one beat, wait (bounded) for acceptance, queue its expectation.
  task automatic send(input bit one, input logic [7:0] d);
    bit ok = 1'b0;
    if (one) begin b1.in_valid = 1'b1; b1.in_data = d; end
    else     begin b4.in_valid = 1'b1; b4.in_data = d; end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (one ? b1.in_ready : b4.in_ready) begin
        ok = 1'b1;
        if (one) q1.push_back('{d, cyc});
        else     q4.push_back('{d, cyc});
        break;
      end
    end
    if (!ok) check("send_timeout", {24'd0, d}, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    if (one) b1.in_valid = 1'b0;
    else     b4.in_valid = 1'b0;
  endtask

  task automatic drain(input bit one, input int budget);
    for (int k = 0; k < budget; k++) begin
      if ((one ? q1.size() : q4.size()) == 0) break;
      cycles(1);
    end
    check(one ? "u1_drain" : "u4_drain", one ? q1.size() : q4.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int base;
    b4.clr = 1'b0; b4.in_valid = 1'b0; b4.in_data = '0; b4.out_ready = 1'b1;
    b1.clr = 1'b0; b1.in_valid = 1'b0; b1.in_data = '0; b1.out_ready = 1'b1;

    // Reset held for three cycles.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", b4.out_valid, 0);
    check("rst_out_data",  b4.out_data, 8'hC3);
    check("rst_occupancy", b4.occupancy, 0);
    check("rst_in_ready",  b4.in_ready, 1);
    check("rst_u1_data",   b1.out_data, 8'h00);
    check("rst_u1_in_ready", b1.in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Streaming 0x01..0x10, latency 4, occupancy steady at 4.
    lat4 = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      send(1'b0, 8'(i));
      if (i == 8) check("stream_occupancy", b4.occupancy, 4);
    end
    drain(1'b0, 20);
    check("stream_count", out4, 16);
    check("stream_empty_occ", b4.occupancy, 0);

    // Back-pressure: fill, stall, then release.
    lat4 = 1'b0;
    base = out4;
    b4.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(1'b0, 8'hA0 + 8'(i));
    b4.in_valid = 1'b1; b4.in_data = 8'hA4;
    @(negedge clk);
    check("bp_in_ready",  b4.in_ready, 0);
    check("bp_occupancy", b4.occupancy, 4);
    check("bp_out_valid", b4.out_valid, 1);
    check("bp_out_data",  b4.out_data, 8'hA0);
    cycles(1);
    @(negedge clk);
    check("bp_out_data_stable", b4.out_data, 8'hA0);
    check("bp_in_ready_stable", b4.in_ready, 0);
    @(posedge clk); #1;
    b4.out_ready = 1'b1;
    send(1'b0, 8'hA4);
    send(1'b0, 8'hA5);
    drain(1'b0, 20);
    check("bp_count", out4 - base, 6);

    // Bubble collapse: 0x11, two idle cycles, 0x22, all stalled.
    b4.out_ready = 1'b0;
    send(1'b0, 8'h11);
    cycles(2);
    send(1'b0, 8'h22);
    cycles(4);
    @(negedge clk);
    check("bub_occupancy", b4.occupancy, 2);
    check("bub_out_data",  b4.out_data, 8'h11);
    check("bub_in_ready",  b4.in_ready, 1);
    @(posedge clk); #1;
    b4.out_ready = 1'b1;
    @(negedge clk);
    check("bub_first",  b4.out_data, 8'h11);
    @(negedge clk);
    check("bub_second_valid", b4.out_valid, 1);
    check("bub_second", b4.out_data, 8'h22);
    @(posedge clk); #1;
    drain(1'b0, 10);

    // Flush with a competing input and a ready consumer.
    b4.out_ready = 1'b0;
    send(1'b0, 8'h31); send(1'b0, 8'h32); send(1'b0, 8'h33);
    check("fl_pre_occupancy", b4.occupancy, 3);
    base = out4;
    b4.clr = 1'b1; b4.in_valid = 1'b1; b4.in_data = 8'h55; b4.out_ready = 1'b1;
    @(negedge clk);
    check("fl_in_ready", b4.in_ready, 0);
    @(posedge clk); #1;
    b4.clr = 1'b0; b4.in_valid = 1'b0;
    q4.delete();
    @(negedge clk);
    check("fl_occupancy", b4.occupancy, 0);
    check("fl_out_valid", b4.out_valid, 0);
    @(posedge clk); #1;
    lat4 = 1'b1;
    send(1'b0, 8'h66);
    drain(1'b0, 10);
    cycles(3);
    check("fl_count", out4 - base, 1);

    // Reset with two beats in flight.
    send(1'b0, 8'h71); send(1'b0, 8'h72);
    base = out4;
    rst_n = 1'b0;
    q4.delete();
    @(negedge clk);
    check("mr_out_valid", b4.out_valid, 0);
    check("mr_occupancy", b4.occupancy, 0);
    check("mr_out_data",  b4.out_data, 8'hC3);
    cycles(2);
    rst_n = 1'b1;
    cycles(6);
    check("mr_no_emit", out4 - base, 0);
    send(1'b0, 8'h73);
    drain(1'b0, 10);
    check("mr_after_count", out4 - base, 1);

    // DEPTH=1: streaming with latency 1, then stall behaviour.
    lat1 = 1'b1;
    for (int i = 1; i <= 16; i++) send(1'b1, 8'(i));
    drain(1'b1, 10);
    check("d1_count", out1, 16);
    lat1 = 1'b0;
    b1.out_ready = 1'b0;
    send(1'b1, 8'h99);
    @(negedge clk);
    check("d1_in_ready_stall", b1.in_ready, 0);
    check("d1_occupancy", b1.occupancy, 1);
    check("d1_out_valid", b1.out_valid, 1);
    @(posedge clk); #1;
    b1.out_ready = 1'b1;
    @(negedge clk);
    check("d1_in_ready_pass", b1.in_ready, 1);
    @(posedge clk); #1;
    drain(1'b1, 10);
    check("d1_final_count", out1, 17);

    cycles(2);
    check("final_q4_empty", q4.size(), 0);
    check("final_q1_empty", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
